// File: rtl/pin_loopback_pkg.sv
// Shared types and the pattern rule for the pin loopback tester.
package pin_loopback_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_APPLY,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic MODE_ALL  = 1'b0;
  localparam logic MODE_WALK = 1'b1;

  // Value of tx bit `ch` for a step. Odd steps drive all-zero. Even steps
  // drive all-ones (all-toggle) or a one-hot bit at walk_idx (walking-one).
  function automatic logic pattern_bit(input logic        mode,
                                       input logic        odd_step,
                                       input int unsigned walk_idx,
                                       input int unsigned ch);
    logic b;
    b = 1'b0;
    if (!odd_step) begin
      case (mode)
        MODE_ALL:  b = 1'b1;
        MODE_WALK: b = (walk_idx == ch);
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/pin_loopback_sync.sv
// Multi-stage flip-flop synchroniser for a bus of independent asynchronous bits.
module pin_loopback_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // NOTE: the synchroniser flops are reset as well, so rx_s is a known 0
  // straight out of reset instead of whatever metastable junk was captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], din};
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/pin_loopback_tester.sv
// Board-level I/O loopback tester: drives patterns on tx, checks the looped-back
// rx within a timeout, and reports sticky per-channel errors and pass/fail.
module pin_loopback_tester
  import pin_loopback_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT       = 64,
  parameter int SETTLE_CYCLES = 256,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic [CNT_WIDTH-1:0] num_steps,
  input  logic [NUM_CH-1:0]    rx,
  output logic [NUM_CH-1:0]    tx,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_CH-1:0]    err_mask,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] step_count
);

  localparam int TMO_W  = (TIMEOUT > 1)       ? $clog2(TIMEOUT)       : 1;
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WALK_W = (NUM_CH > 1)        ? $clog2(NUM_CH)        : 1;

  state_e                state_q, state_d;
  logic [NUM_CH-1:0]     rx_s;
  logic [NUM_CH-1:0]     tx_pat;
  logic                  mode_q;
  logic                  aborted_q;
  logic [CNT_WIDTH-1:0]  num_steps_q;
  logic [SET_W-1:0]      settle_cnt_q;
  logic [TMO_W-1:0]      wait_cnt_q;
  logic [WALK_W-1:0]     walk_idx_q;

  logic active, start_ok, abort_req;
  logic settle_last, rx_match, wait_expired, step_end, last_step;

  pin_loopback_sync #(
    .WIDTH  (NUM_CH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rx),
    .dout  (rx_s)
  );

  assign active       = state_q inside {ST_SETTLE, ST_APPLY, ST_WAIT};
  assign start_ok     = (state_q == ST_IDLE || state_q == ST_DONE) && start;
  assign abort_req    = active && stop;
  assign settle_last  = (state_q == ST_SETTLE) && (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1));
  assign rx_match     = (rx_s == tx);
  assign wait_expired = (wait_cnt_q == TMO_W'(TIMEOUT - 1));
  assign step_end     = (state_q == ST_WAIT) && (rx_match || wait_expired);
  assign last_step    = ((step_count + CNT_WIDTH'(1)) == num_steps_q);

  // Pattern for the step about to be applied.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    tx_pat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tx_pat[i] = pattern_bit(mode_q, step_count[0], 32'(walk_idx_q), unsigned'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (stop)             state_d = ST_DONE;
        else if (settle_last) state_d = (num_steps_q == '0) ? ST_DONE : ST_APPLY;
      end
      ST_APPLY: state_d = stop ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (stop)          state_d = ST_DONE;
        else if (step_end) state_d = last_step ? ST_DONE : ST_APPLY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    busy = active;
    done = (state_q == ST_DONE);
    pass = done && (err_mask == '0) && !aborted_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx           <= '0;
      err_mask     <= '0;
      err_count    <= '0;
      step_count   <= '0;
      mode_q       <= MODE_ALL;
      aborted_q    <= 1'b0;
      num_steps_q  <= '0;
      settle_cnt_q <= '0;
      wait_cnt_q   <= '0;
      walk_idx_q   <= '0;
    end else if (start_ok) begin
      tx           <= '0;
      err_mask     <= '0;
      err_count    <= '0;
      step_count   <= '0;
      mode_q       <= mode;
      aborted_q    <= 1'b0;
      num_steps_q  <= num_steps;
      settle_cnt_q <= '0;
      walk_idx_q   <= '0;
    end else if (abort_req) begin
      aborted_q <= 1'b1;
      tx        <= '0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          settle_cnt_q <= settle_cnt_q + SET_W'(1);
          // Anything high while tx is held low is a stuck-high pin.
          if (settle_last) err_mask <= err_mask | rx_s;
        end
        ST_APPLY: begin
          tx         <= tx_pat;
          wait_cnt_q <= '0;
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q + TMO_W'(1);
          if (step_end) begin
            if (!rx_match) begin
              err_mask <= err_mask | (rx_s ^ tx);
              if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
            end
            step_count <= step_count + CNT_WIDTH'(1);
            if (!step_count[0]) begin
              walk_idx_q <= (walk_idx_q == WALK_W'(NUM_CH - 1)) ? '0 : walk_idx_q + WALK_W'(1);
            end
            if (last_step) tx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_loopback_tester.sv
// Scoreboard bench for pin_loopback_tester with a fault-injecting loopback model.
module tb_pin_loopback_tester;

  localparam int NCH = 4;
  localparam int TMO = 8;
  localparam int SET = 16;
  localparam int CW  = 16;

  typedef struct {
    logic [NCH-1:0] mask;
    logic [CW-1:0]  errs;
    logic [CW-1:0]  steps;
    logic           pass;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           mode = 1'b0;
  logic [CW-1:0]  num_steps = '0;
  logic [NCH-1:0] rx;
  logic [NCH-1:0] tx;
  logic           busy, done, pass;
  logic [NCH-1:0] err_mask;
  logic [CW-1:0]  err_count, step_count;

  // Board fault model: optional short (dst |= src) then stuck-at-0 / stuck-at-1.
  logic [NCH-1:0] s0 = '0;
  logic [NCH-1:0] s1 = '0;
  int             sh_src = 0;
  int             sh_dst = -1;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done_d = 1'b0;

  pin_loopback_tester #(
    .NUM_CH        (NCH),
    .SYNC_STAGES   (2),
    .TIMEOUT       (TMO),
    .SETTLE_CYCLES (SET),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .num_steps  (num_steps),
    .rx         (rx),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_mask   (err_mask),
    .err_count  (err_count),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH-1:0] fault(input logic [NCH-1:0] t);
    logic [NCH-1:0] r;
    r = t;
    if (sh_dst >= 0) r[sh_dst] = r[sh_dst] | t[sh_src];
    return (r & ~s0) | s1;
  endfunction

  always @(tx or s0 or s1 or sh_src or sh_dst) rx = fault(tx);

  function automatic logic [NCH-1:0] pattern(input logic m, input int s);
    logic [NCH-1:0] one;
    one = NCH'(1);
    if (s % 2 == 1) return '0;
    if (!m) return '1;
    return one << ((s / 2) % NCH);
  endfunction

  // Step-level model: rx_s shows the previous step's loopback for the first two
  // cycles, then this step's; a step fails only if neither equals tx.
  function automatic exp_t predict(input logic m, input int n, input int stop_at);
    exp_t           e;
    logic [NCH-1:0] t, prev, r;
    int             steps;
    e.mask = fault('0);
    e.errs = '0;
    prev   = '0;
    steps  = (stop_at >= 0) ? stop_at : n;
    for (int s = 0; s < steps; s++) begin
      t = pattern(m, s);
      r = fault(t);
      if (r != t && fault(prev) != t) begin
        e.mask = e.mask | (r ^ t);
        e.errs = e.errs + CW'(1);
      end
      prev = t;
    end
    e.steps = CW'(steps);
    e.pass  = (e.mask == '0) && (stop_at < 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of done retires one scoreboard entry.
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard, want no done");
      end else begin
        mon_e = sb_q.pop_front();
        check("err_mask",   32'(err_mask),   32'(mon_e.mask));
        check("err_count",  32'(err_count),  32'(mon_e.errs));
        check("step_count", 32'(step_count), 32'(mon_e.steps));
        check("pass",       32'(pass),       32'(mon_e.pass));
        check("done_tx",    32'(tx),         32'h0);
        check("done_busy",  32'(busy),       32'h0);
      end
    end
    done_d = done;
  end

  task automatic run(input logic m, input int n, input int stop_at, input bit extra_start);
    int cycles, stop_cyc, bound;
    bit sent;
    sb_q.push_back(predict(m, n, stop_at));
    bound = SET + n * (TMO + 2) + 4;
    @(negedge clk);
    mode      = m;
    num_steps = CW'(n);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'h1);
    check("done_cleared",     32'(done), 32'h0);
    cycles   = 0;
    stop_cyc = 0;
    sent     = 1'b0;
    while (!done && cycles < bound) begin
      if (stop_at >= 1 && !sent && busy && int'(step_count) == stop_at) begin
        stop     = 1'b1;
        start    = 1'b1;
        sent     = 1'b1;
        stop_cyc = cycles;
      end
      if (extra_start && cycles == 3) begin
        num_steps = CW'(5);
        mode      = ~m;
        start     = 1'b1;
      end
      @(negedge clk);
      cycles++;
      start = 1'b0;
      stop  = 1'b0;
    end
    check("done_in_time", 32'(done), 32'h1);
    if (sent) check("stop_latency", 32'(cycles - stop_cyc), 32'h1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k, kind, b, n, sa;
    logic m;

    // Power-on reset values.
    #12;
    check("rst_tx",         32'(tx),         32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_done",       32'(done),       32'h0);
    check("rst_pass",       32'(pass),       32'h0);
    check("rst_err_mask",   32'(err_mask),   32'h0);
    check("rst_err_count",  32'(err_count),  32'h0);
    check("rst_step_count", 32'(step_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset asserted mid-WAIT with tx all-ones and a settle error already latched.
    s1 = 4'b1000;
    @(negedge clk);
    mode      = 1'b0;
    num_steps = CW'(4);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (tx != 4'hF && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("t1_tx_ones",     32'(tx),       32'hF);
    check("t1_mask_before", 32'(err_mask), 32'h8);
    #2 reset = 1'b1;
    #1;
    check("t1_rst_tx",       32'(tx),         32'h0);
    check("t1_rst_busy",     32'(busy),       32'h0);
    check("t1_rst_done",     32'(done),       32'h0);
    check("t1_rst_err_mask", 32'(err_mask),   32'h0);
    check("t1_rst_steps",    32'(step_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    s1    = '0;

    // Ideal loop, all-toggle.
    run(1'b0, 4, -1, 1'b0);
    // rx[2] stuck low.
    s0 = 4'b0100;
    run(1'b0, 4, -1, 1'b0);
    s0 = '0;
    // rx[1] shorted to tx[0], walking-one.
    sh_src = 0;
    sh_dst = 1;
    run(1'b1, 8, -1, 1'b0);
    sh_dst = -1;
    // Abort after two steps, with start pulsed alongside stop.
    run(1'b0, 10, 2, 1'b0);
    // rx[3] tied high, zero steps, stray start while busy.
    s1 = 4'b1000;
    run(1'b0, 0, -1, 1'b1);
    s1 = '0;

    for (int i = 0; i < 25; i++) begin
      s0     = '0;
      s1     = '0;
      sh_dst = -1;
      kind   = int'($urandom_range(0, 3));
      b      = int'($urandom_range(0, NCH - 1));
      case (kind)
        1: s0[b] = 1'b1;
        2: s1[b] = 1'b1;
        3: begin
          sh_src = b;
          sh_dst = (b + 1 + int'($urandom_range(0, NCH - 2))) % NCH;
        end
        default: ;
      endcase
      m  = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(0, 12));
      sa = -1;
      if (n >= 2 && $urandom_range(0, 3) == 0) sa = int'($urandom_range(1, n - 1));
      run(m, n, sa, 1'b0);
    end

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending runs, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pin_loopback_tester.md
Name: pin_loopback_tester

Overview:
- Parametrised board-level loopback/feedback tester for FPGA I/O pins, for the board test images.
- Drives NUM_CH output pins (tx) and watches NUM_CH externally looped-back input pins (rx).
- Applies a pattern sequence, checks each rx against its tx within a timeout, and reports per-channel sticky errors, a failed-step count and pass/fail.
- Two modes: all-toggle, which catches opens and stuck pins, and walking-one, which also catches shorts between channels.

Parameters:
NUM_CH, 8, number of tx/rx channel pairs (1..32)
SYNC_STAGES, 2, flip-flop synchroniser depth on each rx bit (>=2)
TIMEOUT, 64, max cycles after a pattern is applied for rx to match tx
SETTLE_CYCLES, 256, cycles all-zero is held before the first step
CNT_WIDTH, 16, width of num_steps, step_count and err_count

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
start  input  1  single-cycle pulse; begins a run when not busy
stop  input  1  single-cycle pulse; aborts a run in progress
mode  input  1  0 = all-toggle, 1 = walking-one
num_steps  input  CNT_WIDTH  number of pattern steps in a run; sampled on start
rx  input  NUM_CH  looped-back pins, asynchronous to clk
tx  output  NUM_CH  driven test pattern, registered
busy  output  1  high from an accepted start until done
done  output  1  sticky; set at end of run, cleared by next accepted start
pass  output  1  valid when done: no errors and not aborted
err_mask  output  NUM_CH  sticky per-channel mismatch flags
err_count  output  CNT_WIDTH  failed steps, saturating at all-ones
step_count  output  CNT_WIDTH  completed steps

Behaviour:
- Reset (async assert, sync deassert by the system): every output 0, synchronisers 0, state IDLE.
- rx passes through the SYNC_STAGES synchroniser to give rx_s. All compares use rx_s.
- States: IDLE, SETTLE, APPLY, WAIT, DONE.
- IDLE/DONE + start:
  - Latch mode and num_steps; clear err_mask, err_count, step_count, done and the abort flag.
  - Set tx=0 and busy=1, then go to SETTLE.
- start while busy is ignored.
- SETTLE:
  - Hold tx=0 for SETTLE_CYCLES.
  - On the last cycle, any rx_s bit =1 is OR'd into err_mask (stuck-high). This does not count as a step.
  - Go to APPLY, or to DONE if num_steps=0.
- APPLY (1 cycle):
  - tx <= pattern(step_count).
  - Timeout counter cleared; go to WAIT.
- Patterns:
  - mode 0: even steps all-ones, odd steps all-zero.
  - mode 1: even step 2k gives one-hot bit (k mod NUM_CH); odd steps all-zero.
- WAIT:
  - Each cycle, compare rx_s == tx.
  - Match, checked on cycles 1..TIMEOUT after APPLY: the step passes.
  - No match after TIMEOUT cycles: err_mask |= rx_s ^ tx, and err_count increments (saturating).
  - In either case step_count increments; go to APPLY, or to DONE when step_count reaches num_steps.
- DONE: tx=0, busy=0, done=1, pass = (err_mask==0) && !aborted.
- stop in SETTLE/APPLY/WAIT: abort flag set, go to DONE next cycle; step_count keeps its value. stop in IDLE/DONE is ignored.
- Simultaneous start and stop while busy: stop wins.
- step_count wraps only after num_steps is reached, which cannot happen. err_count saturates.
- Pattern index for mode 1 uses a log2(NUM_CH) counter that wraps at NUM_CH.

Decomposition:
- Package pin_loopback_pkg:
  - state enum;
  - MODE_ALL=1'b0 and MODE_WALK=1'b1 constants;
  - pattern-function helper.
- Sub-module pin_loopback_sync: a SYNC_STAGES-deep synchroniser on a width-parametrised bus, reset to 0.
- FSM, counters and checker live in the top module.

Test Plan:
All scenarios use NUM_CH=4, SYNC_STAGES=2, TIMEOUT=8, SETTLE_CYCLES=16.
1. Assert reset mid-WAIT with tx=4'b1111 -> tx=0, busy=0, done=0, err_mask=0 in the same cycle as reset asserts; state IDLE.
2. rx=tx (ideal loop), mode 0, num_steps=4, start -> done within 16+4*(TIMEOUT+2) cycles; pass=1, err_mask=0, err_count=0, step_count=4.
3. rx[2] stuck 0, mode 0, num_steps=4 -> err_mask=4'b0100, err_count=2 (steps 0 and 2), pass=0.
4. rx[1]=tx[0]|tx[1] (short), mode 1, num_steps=8 -> patterns 0001,0000,0010,0000,0100,0000,1000,0000; err_mask=4'b0010, err_count=1, pass=0.
5. rx=tx, mode 0, num_steps=10; stop after step_count=2 -> next cycle done=1, busy=0, tx=0, pass=0, step_count=2.
6. rx[3] tied 1, num_steps=0 -> SETTLE flags err_mask=4'b1000, done=1, pass=0, err_count=0; a second start while busy is ignored.
